// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler
//   Sequences one test frame over the UART loopback: HEADER, PAYLOAD_LEN
//   payload bytes (SEED + i) and a CRC byte. Owns the uart_tx handshake and
//   time-shares the single external crc8: the TX CRC is precomputed first,
//   then the unit is handed to the RX checker for the looped-back bytes.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle frame request (ignored while busy)
//   tx_busy             uart_tx busy
//   tx_start, tx_data   one-cycle send request and its byte
//   rx_done, rx_data    uart_rx byte strobe and byte
//   crc_init            one-cycle clear of crc8
//   crc_data_valid      one-cycle crc8 update strobe, byte on crc_data_in
//   crc_out             crc8 result (one cycle after the last update)
//   display_status      00 idle, 01 busy, 10 pass, 11 fail
module uart_frame_scheduler #(
  parameter int unsigned PAYLOAD_LEN    = 4,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [7:0]  SEED           = 8'h30,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       crc_init,
  output logic       crc_data_valid,
  output logic [7:0] crc_data_in,
  input  logic [7:0] crc_out,
  output logic [1:0] display_status
);

  // Byte counters are 8 bits; one extra bit only when N+2 would not fit.
  localparam int unsigned CW = (PAYLOAD_LEN + 2 > 255) ? 9 : 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_CALC = CW'(PAYLOAD_LEN - 1);
  localparam logic [CW-1:0] CRC_POS   = CW'(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] FRAME_LEN = CW'(PAYLOAD_LEN + 2);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_PASS = 2'b10;
  localparam logic [1:0] ST_FAIL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE_INIT, S_CALC, S_LATCH, S_SEND, S_SEND_WAIT, S_RX_WAIT,
    S_PASS, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tx_idx_q, tx_idx_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            wait_q, wait_d;
  logic            err_q, err_d;
  logic [7:0]      tx_crc_q, tx_crc_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            crc_init_q, crc_init_d;
  logic            crc_valid_q, crc_valid_d;
  logic [7:0]      crc_din_q, crc_din_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      tx_byte;
  logic            rx_active;

  always_comb begin
    if (tx_idx_q == '0)          tx_byte = HEADER;
    else if (tx_idx_q == CRC_POS) tx_byte = tx_crc_q;
    else                          tx_byte = SEED + tx_idx_q[7:0] - 8'd1;
  end

  assign rx_active = (state_q == S_SEND) || (state_q == S_SEND_WAIT) ||
                     (state_q == S_RX_WAIT);

  always_comb begin
    state_d     = state_q;
    tx_idx_d    = tx_idx_q;
    rx_cnt_d    = rx_cnt_q;
    to_cnt_d    = to_cnt_q;
    wait_d      = wait_q;
    err_d       = err_q;
    tx_crc_d    = tx_crc_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    crc_init_d  = 1'b0;
    crc_valid_d = 1'b0;
    crc_din_d   = crc_din_q;
    status_d    = status_q;

    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d  = S_PRE_INIT;
          status_d = ST_BUSY;
          tx_idx_d = '0;
          rx_cnt_d = '0;
          to_cnt_d = '0;
          err_d    = 1'b0;
        end
      end
      S_PRE_INIT: begin
        crc_init_d = 1'b1;
        tx_idx_d   = '0;
        state_d    = S_CALC;
      end
      S_CALC: begin
        // tx_idx doubles as the payload step counter here.
        crc_valid_d = 1'b1;
        crc_din_d   = SEED + tx_idx_q[7:0];
        tx_idx_d    = tx_idx_q + CW'(1);
        if (tx_idx_q == LAST_CALC) begin
          tx_idx_d = '0;
          wait_d   = 1'b1;
          state_d  = S_LATCH;
        end
      end
      S_LATCH: begin
        // First cycle: last update strobe is still on the wire.
        if (wait_q) begin
          wait_d = 1'b0;
        end else begin
          tx_crc_d   = crc_out;
          crc_init_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_byte;
          wait_d     = 1'b1;
          state_d    = S_SEND_WAIT;
        end
      end
      S_SEND_WAIT: begin
        // tx_busy is not yet meaningful in the cycle carrying tx_start.
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (!tx_busy) begin
          tx_idx_d = tx_idx_q + CW'(1);
          if (tx_idx_q == CRC_POS) begin
            to_cnt_d = '0;
            state_d  = S_RX_WAIT;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_RX_WAIT: begin
        if (rx_cnt_q == FRAME_LEN) begin
          state_d  = err_q ? S_FAIL : S_PASS;
          status_d = err_q ? ST_FAIL : ST_PASS;
        end else if (to_cnt_q == TO_MAX) begin
          state_d  = S_FAIL;
          status_d = ST_FAIL;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loopback bytes arrive while still transmitting, so the checker runs
    // alongside SEND/SEND_WAIT. It is the only crc8 user after LATCH.
    if (rx_active && rx_done) begin
      to_cnt_d = '0;
      if (rx_cnt_q != FRAME_LEN) begin
        rx_cnt_d = rx_cnt_q + CW'(1);
        if (rx_cnt_q == '0) begin
          if (rx_data != HEADER) err_d = 1'b1;
        end else if (rx_cnt_q == CRC_POS) begin
          if (rx_data != crc_out) err_d = 1'b1;
        end else begin
          crc_valid_d = 1'b1;
          crc_din_d   = rx_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tx_idx_q    <= '0;
      rx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      wait_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_crc_q    <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      crc_init_q  <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_din_q   <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      tx_idx_q    <= tx_idx_d;
      rx_cnt_q    <= rx_cnt_d;
      to_cnt_q    <= to_cnt_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      tx_crc_q    <= tx_crc_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      crc_init_q  <= crc_init_d;
      crc_valid_q <= crc_valid_d;
      crc_din_q   <= crc_din_d;
      status_q    <= status_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign crc_init       = crc_init_q;
  assign crc_data_valid = crc_valid_q;
  assign crc_data_in    = crc_din_q;
  assign display_status = status_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler
//   Drives uart_frame_scheduler with a uart_tx/uart_rx loopback responder
//   (random busy lengths, optional byte corruption) and a CRC-8 unit
//   (poly 0x07, init 0x00, MSB first). Frame-level expectations come from
//   a reference model: the tx byte list and the pass/fail verdict are
//   computed from the bytes actually sent and received.
module tb_uart_frame_scheduler;

  localparam int unsigned N       = 4;
  localparam logic [7:0]  HDR     = 8'hA5;
  localparam logic [7:0]  SD      = 8'h30;
  localparam int unsigned TO_CYC  = 1000;

  logic       clk = 1'b0;
  logic       reset, start, tx_busy, rx_done;
  logic [7:0] rx_data;
  logic       tx_start, crc_init, crc_data_valid;
  logic [7:0] tx_data, crc_data_in;
  logic [7:0] crc_out = 8'h00;
  logic [1:0] display_status;

  uart_frame_scheduler #(
    .PAYLOAD_LEN(N), .HEADER(HDR), .SEED(SD), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .rx_done(rx_done),
    .rx_data(rx_data), .crc_init(crc_init), .crc_data_valid(crc_data_valid),
    .crc_data_in(crc_data_in), .crc_out(crc_out),
    .display_status(display_status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlap_cnt = 0;
  int busy_viol   = 0;
  int tx_pulses   = 0;
  int busy_left   = 0;
  int corrupt_idx = -1;
  logic [7:0] corrupt_mask = 8'h00;
  logic [7:0] cur_byte = 8'h00;
  bit   loop_en = 1'b1;
  logic [7:0] tx_log[$];
  logic [7:0] rx_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                           input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  // External crc8 unit and overlap monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crc_init && crc_data_valid) overlap_cnt <= overlap_cnt + 1;
    if (crc_init) crc_out <= 8'h00;
    else if (crc_data_valid) crc_out <= crc8_step(crc_out, crc_data_in);
  end

  // uart_tx / uart_rx loopback responder.
  always @(negedge clk) begin
    rx_done = 1'b0;
    if (tx_busy) begin
      if (tx_start) busy_viol++;
      busy_left--;
      if (busy_left == 0) begin
        tx_busy = 1'b0;
        if (loop_en) begin
          rx_data = cur_byte ^ ((rx_log.size() == corrupt_idx) ? corrupt_mask : 8'h00);
          rx_done = 1'b1;
          rx_log.push_back(rx_data);
        end
      end
    end else if (tx_start) begin
      tx_pulses++;
      tx_log.push_back(tx_data);
      cur_byte  = tx_data;
      tx_busy   = 1'b1;
      busy_left = int'($urandom_range(3, 8));
    end
  end

  // Reference model: frame bytes from the construction rule.
  function automatic logic [7:0] exp_tx_byte(input int i);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < N; k++) c = crc8_step(c, SD + 8'(k));
    if (i == 0) return HDR;
    if (i == N + 1) return c;
    return SD + 8'(i - 1);
  endfunction

  function automatic logic [1:0] exp_verdict();
    logic [7:0] c;
    if (rx_log.size() != N + 2) return 2'b11;
    c = 8'h00;
    for (int k = 1; k <= N; k++) c = crc8_step(c, rx_log[k]);
    return (rx_log[0] == HDR && rx_log[N+1] == c) ? 2'b10 : 2'b11;
  endfunction

  task automatic begin_frame(input int cidx, input logic [7:0] cmask);
    tx_log.delete();
    rx_log.delete();
    tx_pulses    = 0;
    corrupt_idx  = cidx;
    corrupt_mask = cmask;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("status_busy_after_start", 32'(display_status), 32'h1);
  endtask

  task automatic run_frame(input string tag, input int cidx,
                           input logic [7:0] cmask, input int restart_at);
    bit done, early, restarted;
    done = 0; early = 0; restarted = 0;
    begin_frame(cidx, cmask);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_at >= 0 && !restarted && tx_pulses == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (display_status != 2'b01) begin
        if (rx_log.size() < N + 2) early = 1;
        done = 1;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, "_done"}, 32'(done), 32'h1);
    check_eq({tag, "_early_verdict"}, 32'(early), 32'h0);
    check_eq({tag, "_tx_pulses"}, 32'(tx_pulses), N + 2);
    for (int i = 0; i < N + 2; i++)
      check_eq($sformatf("%s_tx_byte%0d", tag, i),
               32'((i < tx_log.size()) ? tx_log[i] : 8'hxx), 32'(exp_tx_byte(i)));
    check_eq({tag, "_status"}, 32'(display_status), 32'(exp_verdict()));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int p;
    bit seen;
    reset = 1'b1; start = 1'b0; tx_busy = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_start", 32'(tx_start), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    check_eq("rst_crc_init", 32'(crc_init), 32'h0);
    check_eq("rst_crc_valid", 32'(crc_data_valid), 32'h0);
    check_eq("rst_crc_din", 32'(crc_data_in), 32'h0);
    check_eq("rst_status", 32'(display_status), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("loopback", -1, 8'h00, -1);
    run_frame("payload_flip", 2, 8'h01, -1);
    run_frame("bad_header", 0, 8'hFF, -1);
    run_frame("crc_flip", N + 1, 8'h80, -1);
    run_frame("restart_ignored", -1, 8'h00, 2);
    run_frame("start_after_pass", -1, 8'h00, -1);

    for (int r = 0; r < 5; r++) begin
      if ($urandom_range(0, 1) == 0)
        run_frame($sformatf("rand%0d", r), -1, 8'h00, -1);
      else
        run_frame($sformatf("rand%0d", r), int'($urandom_range(0, N + 1)),
                  8'(1 << $urandom_range(0, 7)), -1);
    end

    // Loopback cut: all bytes go out, verdict only after the timeout.
    loop_en = 1'b0;
    begin_frame(-1, 8'h00);
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (tx_pulses == N + 2 && !tx_busy) begin seen = 1; break; end
    end
    check_eq("timeout_all_sent", 32'(seen), 32'h1);
    repeat (TO_CYC - 25) @(negedge clk);
    check_eq("timeout_not_early", 32'(display_status), 32'h1);
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (display_status != 2'b01) begin seen = 1; break; end
    end
    check_eq("timeout_expired", 32'(seen), 32'h1);
    check_eq("timeout_status", 32'(display_status), 32'h3);
    check_eq("timeout_tx_pulses", 32'(tx_pulses), N + 2);
    loop_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during the third SEND_WAIT.
    begin_frame(-1, 8'h00);
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx_pulses == 3) begin seen = 1; break; end
    end
    check_eq("reset_reach_third", 32'(seen), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("reset_mid_tx_start", 32'(tx_start), 32'h0);
    check_eq("reset_mid_status", 32'(display_status), 32'h0);
    reset = 1'b0;
    p = tx_pulses;
    repeat (60) @(negedge clk);
    check_eq("reset_no_more_tx", 32'(tx_pulses), 32'(p));
    check_eq("reset_stays_idle", 32'(display_status), 32'h0);

    run_frame("after_reset", -1, 8'h00, -1);

    check_eq("crc_no_overlap", 32'(overlap_cnt), 32'h0);
    check_eq("tx_start_while_busy", 32'(busy_viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
